// File: rtl/lock_code_sender.sv
// lock_code_sender: stimulus-side master for a combination lock.
// Holds a small programmable code sequence and plays it out one code at a
// time. After each code it checks the lock's state and unlocked feedback,
// then reports a sticky done or error flag.
module lock_code_sender #(
  parameter int                DEPTH     = 4,
  parameter int                CODE_W    = 4,
  parameter int                STATE_W   = 2,
  parameter int                GAP       = 1,
  parameter logic [CODE_W-1:0] IDLE_CODE = 4'hF,
  localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [CODE_W-1:0]  cfg_data,
  input  logic [3:0]         cfg_len,
  input  logic               start,
  input  logic [STATE_W-1:0] lock_state,
  input  logic               lock_unlocked,
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [3:0]         step
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_CHECK,
    S_WAIT,
    S_FIN
  } state_t;

  localparam logic [4:0] DEPTH_L = 5'(DEPTH);
  localparam logic [2:0] GAP_M1  = 3'(GAP - 1);

  state_t             state;
  logic [CODE_W-1:0]  ram [DEPTH];
  logic [3:0]         len;
  logic [2:0]         wait_cnt;
  // Outcome of a start-time rejection, published to done/error in FIN.
  logic               pend_done;
  logic               pend_err;

  logic [3:0]         step_nx;
  logic               len_bad;
  logic               state_ok;
  logic               last_step;
  logic [CODE_W-1:0]  ram_cur;
  logic [CODE_W-1:0]  ram_nx;

  // Helpers for the start checks and per-code checks.
  always_comb begin
    step_nx   = step + 4'd1;
    len_bad   = (cfg_len == 4'd0) || ({1'b0, cfg_len} > DEPTH_L);
    // The lock advances one state per accepted code, so after code 'step'
    // it should sit in state step+1 (wrapping at the state width).
    state_ok  = (lock_state == STATE_W'(step_nx));
    last_step = (step == (len - 4'd1));
    ram_cur   = ram[step[AW-1:0]];
    ram_nx    = ram[step_nx[AW-1:0]];
  end

  // Sequence RAM: cleared by reset, writable only while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
      end
    end else if (state == S_IDLE && cfg_we) begin
      ram[cfg_addr] <= cfg_data;
    end
  end

  // Main sequencer: every output is registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      code       <= IDLE_CODE;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      step       <= 4'd0;
      len        <= 4'd0;
      wait_cnt   <= 3'd0;
      pend_done  <= 1'b0;
      pend_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          code       <= IDLE_CODE;
          code_valid <= 1'b0;
          if (start) begin
            len       <= cfg_len;
            done      <= 1'b0;
            error     <= 1'b0;
            step      <= 4'd0;
            busy      <= 1'b1;
            pend_done <= 1'b0;
            pend_err  <= 1'b0;
            // Checks are ordered: a bad length wins over an already-open
            // lock, which wins over a lock that is mid-sequence.
            if (len_bad) begin
              pend_err <= 1'b1;
              state    <= S_FIN;
            end else if (lock_unlocked) begin
              pend_done <= 1'b1;
              state     <= S_FIN;
            end else if (lock_state != '0) begin
              pend_err <= 1'b1;
              state    <= S_FIN;
            end else begin
              // First code goes out in the cycle right after start.
              code       <= ram[0];
              code_valid <= 1'b1;
              state      <= S_SEND;
            end
          end
        end

        S_SEND: begin
          code       <= IDLE_CODE;
          code_valid <= 1'b0;
          state      <= S_CHECK;
        end

        S_CHECK: begin
          if (!state_ok) begin
            error <= 1'b1;
            state <= S_FIN;
          end else if (last_step) begin
            if (lock_unlocked) begin
              done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
            state <= S_FIN;
          end else begin
            step <= step_nx;
            if (GAP == 0) begin
              code       <= ram_nx;
              code_valid <= 1'b1;
              state      <= S_SEND;
            end else begin
              wait_cnt <= GAP_M1;
              state    <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            code       <= ram_cur;
            code_valid <= 1'b1;
            state      <= S_SEND;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        S_FIN: begin
          busy      <= 1'b0;
          state     <= S_IDLE;
          pend_done <= 1'b0;
          pend_err  <= 1'b0;
          if (pend_done) begin
            done <= 1'b1;
          end
          if (pend_err) begin
            error <= 1'b1;
          end
        end

        default: begin
          code       <= IDLE_CODE;
          code_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_code_sender.sv
// Testbench for lock_code_sender: two instances (GAP=1 and GAP=0), each
// driving its own behavioural 6-4-3 lock.
module tb_lock_code_sender;

  typedef struct {
    logic [3:0] code;
    logic       vld;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] step;
  } row_t;

  logic       clk;
  logic       reset_n;
  logic       lock_clr;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_data;
  logic [3:0] cfg_len;

  logic       we1, start1, valid1, busy1, done1, err1;
  logic [3:0] code1, step1;
  logic [1:0] ls1;
  logic       unl1;

  logic       we0, start0, valid0, busy0, done0, err0;
  logic [3:0] code0, step0;
  logic [1:0] ls0;
  logic       unl0;

  int ntests;
  int nfail;

  row_t main_tbl[10];
  row_t g0_tbl[8];

  lock_code_sender #(.DEPTH(4), .CODE_W(4), .STATE_W(2), .GAP(1), .IDLE_CODE(4'hF)) u1 (
    .clk(clk), .reset_n(reset_n), .cfg_we(we1), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start1),
    .lock_state(ls1), .lock_unlocked(unl1), .code(code1), .code_valid(valid1),
    .busy(busy1), .done(done1), .error(err1), .step(step1)
  );

  lock_code_sender #(.DEPTH(4), .CODE_W(4), .STATE_W(2), .GAP(0), .IDLE_CODE(4'hF)) u0 (
    .clk(clk), .reset_n(reset_n), .cfg_we(we0), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start0),
    .lock_state(ls0), .lock_unlocked(unl0), .code(code0), .code_valid(valid0),
    .busy(busy0), .done(done0), .error(err0), .step(step0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 6-4-3 lock: advances on the right code, holds on a wrong one.
  function automatic logic [1:0] lock_next(input logic [1:0] s, input logic [3:0] c);
    logic [3:0] want;
    case (s)
      2'd0:    want = 4'd6;
      2'd1:    want = 4'd4;
      2'd2:    want = 4'd3;
      default: want = 4'hF;
    endcase
    lock_next = (s != 2'd3 && c == want) ? s + 2'd1 : s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ls1 <= 2'd0;
      ls0 <= 2'd0;
    end else if (lock_clr) begin
      ls1 <= 2'd0;
      ls0 <= 2'd0;
    end else begin
      if (valid1) ls1 <= lock_next(ls1, code1);
      if (valid0) ls0 <= lock_next(ls0, code0);
    end
  end

  assign unl1 = (ls1 == 2'd3);
  assign unl0 = (ls0 == 2'd3);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string tag, input int c, input row_t r,
                         input logic [3:0] code, input logic v, input logic b,
                         input logic d, input logic e, input logic [3:0] s);
    check($sformatf("%s c%0d code", tag, c), 32'(code), 32'(r.code));
    check($sformatf("%s c%0d valid", tag, c), 32'(v), 32'(r.vld));
    check($sformatf("%s c%0d busy", tag, c), 32'(b), 32'(r.busy));
    check($sformatf("%s c%0d done", tag, c), 32'(d), 32'(r.done));
    check($sformatf("%s c%0d error", tag, c), 32'(e), 32'(r.err));
    check($sformatf("%s c%0d step", tag, c), 32'(s), 32'(r.step));
  endtask

  task automatic prog(input bit gap0, input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] d2);
    logic [3:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int i = 0; i < 3; i++) begin
      cfg_addr = 2'(i);
      cfg_data = d[i];
      if (gap0) we0 = 1'b1; else we1 = 1'b1;
      tick();
    end
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  task automatic pulse_lock_clr();
    lock_clr = 1'b1;
    tick();
    lock_clr = 1'b0;
  endtask

  initial begin
    int vc;
    bit saw3;

    main_tbl[0] = '{4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    main_tbl[1] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    main_tbl[2] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    main_tbl[3] = '{4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    main_tbl[4] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    main_tbl[5] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
    main_tbl[6] = '{4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
    main_tbl[7] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
    main_tbl[8] = '{4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
    main_tbl[9] = '{4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};

    g0_tbl[0] = '{4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    g0_tbl[1] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    g0_tbl[2] = '{4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    g0_tbl[3] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    g0_tbl[4] = '{4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
    g0_tbl[5] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
    g0_tbl[6] = '{4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
    g0_tbl[7] = '{4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};

    ntests = 0;
    nfail = 0;
    reset_n = 1'b0;
    lock_clr = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = 4'd0;
    cfg_len = 4'd0;
    we1 = 1'b0; start1 = 1'b0;
    we0 = 1'b0; start0 = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst code", 32'(code1), 32'hF);
    check("rst valid", 32'(valid1), 32'd0);
    check("rst busy", 32'(busy1), 32'd0);
    check("rst done", 32'(done1), 32'd0);
    check("rst error", 32'(err1), 32'd0);
    check("rst step", 32'(step1), 32'd0);
    reset_n = 1'b1;
    tick();

    // Good sequence 6-4-3, GAP=1
    prog(1'b0, 4'd6, 4'd4, 4'd3);
    cfg_len = 4'd3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_row("seq", i + 1, main_tbl[i], code1, valid1, busy1, done1, err1, step1);
      if (i < 9) tick();
    end
    check("seq lock unlocked", 32'(unl1), 32'd1);

    // Lock already open at start: done after 2 cycles, no codes sent
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("open c1 done cleared", 32'(done1), 32'd0);
    check("open c1 busy", 32'(busy1), 32'd1);
    check("open c1 valid", 32'(valid1), 32'd0);
    tick();
    check("open c2 done", 32'(done1), 32'd1);
    check("open c2 error", 32'(err1), 32'd0);
    check("open c2 busy", 32'(busy1), 32'd0);
    check("open c2 valid", 32'(valid1), 32'd0);

    // Wrong second code 5: lock stays in state 1, error at cycle 6
    pulse_lock_clr();
    prog(1'b0, 4'd6, 4'd5, 4'd3);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    vc = 0;
    saw3 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (valid1) begin
        vc++;
        if (code1 == 4'd3) saw3 = 1'b1;
      end
      if (c == 5) check("bad c5 lock_state", 32'(ls1), 32'd1);
      if (c == 6) begin
        check("bad c6 error", 32'(err1), 32'd1);
        check("bad c6 done", 32'(done1), 32'd0);
        check("bad c6 step", 32'(step1), 32'd1);
      end
      tick();
    end
    check("bad code pulses", 32'(vc), 32'd2);
    check("bad code 3 driven", 32'(saw3), 32'd0);

    // Lock left mid-sequence (state 1): start is rejected
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("midlock c1 valid", 32'(valid1), 32'd0);
    tick();
    check("midlock c2 error", 32'(err1), 32'd1);

    // Length 0 and length above DEPTH are rejected
    pulse_lock_clr();
    cfg_len = 4'd0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check("len0 c2 error", 32'(err1), 32'd1);
    check("len0 c2 done", 32'(done1), 32'd0);
    cfg_len = 4'd5;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("len5 c1 error cleared", 32'(err1), 32'd0);
    tick();
    check("len5 c2 error", 32'(err1), 32'd1);
    cfg_len = 4'd3;

    // GAP=0 instance, with start and cfg_we pulses while busy
    prog(1'b1, 4'd6, 4'd4, 4'd3);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_row("gap0", i + 1, g0_tbl[i], code0, valid0, busy0, done0, err0, step0);
      if (i == 1) begin
        cfg_addr = 2'd0;
        cfg_data = 4'd9;
        we0 = 1'b1;
      end else if (i == 2) begin
        we0 = 1'b0;
        start0 = 1'b1;
      end else begin
        start0 = 1'b0;
      end
      if (i < 7) tick();
    end
    tick();
    check("gap0 no restart busy", 32'(busy0), 32'd0);
    pulse_lock_clr();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("gap0 ram kept code", 32'(code0), 32'd6);
    check("gap0 ram kept valid", 32'(valid0), 32'd1);
    for (int i = 0; i < 8; i++) tick();

    // Reset during the WAIT after code 6
    pulse_lock_clr();
    prog(1'b0, 4'd6, 4'd4, 4'd3);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("arst code", 32'(code1), 32'hF);
    check("arst busy", 32'(busy1), 32'd0);
    check("arst done", 32'(done1), 32'd0);
    check("arst error", 32'(err1), 32'd0);
    check("arst valid", 32'(valid1), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("rerun c1 code", 32'(code1), 32'd0);
    check("rerun c1 valid", 32'(valid1), 32'd1);
    tick();
    tick();
    check("rerun c3 error", 32'(err1), 32'd1);
    check("rerun c3 done", 32'(done1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
